// File: rtl/fifo_sched_ctrl.sv
// Pointer, occupancy and arbitration controller for a single-port-per-cycle FIFO
// storage array: issues at most one write or one read per clock, round-robin on ties.
module fifo_sched_ctrl #(
  parameter int W        = 2,
  parameter int AF_LEVEL = 3,
  parameter int AE_LEVEL = 1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         wr_req,
  input  logic         rd_req,
  output logic         wr_gnt,
  output logic         rd_gnt,
  output logic         mem_wr_en,
  output logic         mem_re_en,
  output logic [W-1:0] mem_w_addr,
  output logic [W-1:0] mem_r_addr,
  output logic         rd_valid,
  output logic [W:0]   count,
  output logic         full,
  output logic         empty,
  output logic         almost_full,
  output logic         almost_empty
);

  localparam logic [W:0] DEPTH = (W+1)'(2**W);
  localparam logic [W:0] AF_L  = (W+1)'(AF_LEVEL);
  localparam logic [W:0] AE_L  = (W+1)'(AE_LEVEL);

  typedef enum logic {
    GNT_WRITE = 1'b0,
    GNT_READ  = 1'b1
  } gnt_e;

  gnt_e         last_gnt_reg, last_gnt_next;
  logic [W-1:0] wr_ptr_reg, wr_ptr_next;
  logic [W-1:0] rd_ptr_reg, rd_ptr_next;
  logic [W:0]   count_reg, count_next;
  logic         rd_valid_reg;
  logic         wr_ok, rd_ok;

  // Flags come straight from the registered occupancy.
  assign full         = (count_reg == DEPTH);
  assign empty        = (count_reg == '0);
  assign almost_full  = (count_reg >= AF_L);
  assign almost_empty = (count_reg <= AE_L);

  assign count      = count_reg;
  assign rd_valid   = rd_valid_reg;
  assign mem_wr_en  = wr_gnt;
  assign mem_re_en  = rd_gnt;
  assign mem_w_addr = wr_ptr_reg;
  assign mem_r_addr = rd_ptr_reg;

  always_comb begin
    wr_gnt        = 1'b0;
    rd_gnt        = 1'b0;
    last_gnt_next = last_gnt_reg;
    wr_ptr_next   = wr_ptr_reg;
    rd_ptr_next   = rd_ptr_reg;
    count_next    = count_reg;

    // Gating with rst_n keeps grants (and storage enables) quiet while reset is held.
    wr_ok = rst_n & wr_req & ~full;
    rd_ok = rst_n & rd_req & ~empty;

    if (wr_ok && rd_ok) begin
      if (last_gnt_reg == GNT_READ) wr_gnt = 1'b1;
      else                          rd_gnt = 1'b1;
    end else begin
      wr_gnt = wr_ok;
      rd_gnt = rd_ok;
    end

    if (wr_gnt) begin
      last_gnt_next = GNT_WRITE;
      wr_ptr_next   = wr_ptr_reg + W'(1);
      count_next    = count_reg + (W+1)'(1);
    end else if (rd_gnt) begin
      last_gnt_next = GNT_READ;
      rd_ptr_next   = rd_ptr_reg + W'(1);
      count_next    = count_reg - (W+1)'(1);
    end
  end

  // Resetting last_gnt to READ hands the first tie after reset to the writer.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_gnt_reg <= GNT_READ;
      wr_ptr_reg   <= '0;
      rd_ptr_reg   <= '0;
      count_reg    <= '0;
      rd_valid_reg <= 1'b0;
    end else begin
      last_gnt_reg <= last_gnt_next;
      wr_ptr_reg   <= wr_ptr_next;
      rd_ptr_reg   <= rd_ptr_next;
      count_reg    <= count_next;
      rd_valid_reg <= rd_gnt;
    end
  end

endmodule

// File: tb/tb_fifo_sched_ctrl.sv
// Scoreboard bench for fifo_sched_ctrl: a queue-based FIFO model predicts grants and
// flags; popped words are queued and checked against storage output on rd_valid.
module tb_fifo_sched_ctrl;

  localparam int W  = 2;
  localparam int D  = 4;
  localparam int AF = 3;
  localparam int AE = 1;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         wr_req = 1'b0;
  logic         rd_req = 1'b0;
  logic         wr_gnt, rd_gnt, mem_wr_en, mem_re_en;
  logic [W-1:0] mem_w_addr, mem_r_addr;
  logic         rd_valid;
  logic [W:0]   count;
  logic         full, empty, almost_full, almost_empty;

  logic [7:0]   wr_data = 8'h00;
  logic [7:0]   r_data = 8'h00;
  logic [7:0]   store [D];

  int errors = 0;
  int checks = 0;

  // Reference model state
  byte unsigned model_q[$];
  byte unsigned sb_q[$];
  int  pushes = 0;
  int  pops = 0;
  bit  last_was_read = 1'b1;

  fifo_sched_ctrl #(.W(W), .AF_LEVEL(AF), .AE_LEVEL(AE)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .wr_req       (wr_req),
    .rd_req       (rd_req),
    .wr_gnt       (wr_gnt),
    .rd_gnt       (rd_gnt),
    .mem_wr_en    (mem_wr_en),
    .mem_re_en    (mem_re_en),
    .mem_w_addr   (mem_w_addr),
    .mem_r_addr   (mem_r_addr),
    .rd_valid     (rd_valid),
    .count        (count),
    .full         (full),
    .empty        (empty),
    .almost_full  (almost_full),
    .almost_empty (almost_empty)
  );

  always #5 clk = ~clk;

  // Write-priority storage with registered read
  always @(posedge clk) begin
    if (mem_wr_en) store[mem_w_addr] <= wr_data;
    else if (mem_re_en) r_data <= store[mem_r_addr];
  end

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitor: every rd_valid must match the oldest outstanding popped word
  always @(negedge clk) begin
    if (rd_valid) begin
      if (sb_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL rd_valid_spurious: got rd_valid=1 expected 0 (t=%0t)", $time);
      end else begin
        chk("r_data", int'(r_data), int'(sb_q.pop_front()));
      end
    end
  end

  task automatic model_reset();
    model_q.delete();
    sb_q.delete();
    pushes = 0;
    pops = 0;
    last_was_read = 1'b1;
  endtask

  // One clock: drive requests, predict from the model, compare, then commit the model.
  task automatic cycle(input bit wr, input bit rd);
    int  sz;
    bit  wok, rok, ewg, erg;
    @(negedge clk);
    wr_req  = wr;
    rd_req  = rd;
    wr_data = 8'($urandom);
    #1;
    sz  = model_q.size();
    wok = wr && (sz < D);
    rok = rd && (sz > 0);
    ewg = wok && (!rok || last_was_read);
    erg = rok && !ewg;
    chk("wr_gnt", int'(wr_gnt), int'(ewg));
    chk("rd_gnt", int'(rd_gnt), int'(erg));
    chk("mem_wr_en", int'(mem_wr_en), int'(ewg));
    chk("mem_re_en", int'(mem_re_en), int'(erg));
    chk("count", int'(count), sz);
    chk("full", int'(full), int'(sz == D));
    chk("empty", int'(empty), int'(sz == 0));
    chk("almost_full", int'(almost_full), int'(sz >= AF));
    chk("almost_empty", int'(almost_empty), int'(sz <= AE));
    if (ewg) begin
      chk("mem_w_addr", int'(mem_w_addr), pushes % D);
      model_q.push_back(wr_data);
      pushes++;
      last_was_read = 1'b0;
    end
    if (erg) begin
      chk("mem_r_addr", int'(mem_r_addr), pops % D);
      sb_q.push_back(model_q.pop_front());
      pops++;
      last_was_read = 1'b1;
    end
    $display("cyc t=%0t wr_req=%0b rd_req=%0b wr_gnt=%0b rd_gnt=%0b count=%0d", $time,
             wr, rd, wr_gnt, rd_gnt, count);
  endtask

  // Asynchronous reset held across one rising edge, requests asserted throughout.
  task automatic pulse_reset();
    rst_n  = 1'b0;
    wr_req = 1'b1;
    rd_req = 1'b1;
    #1;
    model_reset();
    chk("rst_count", int'(count), 0);
    chk("rst_empty", int'(empty), 1);
    chk("rst_full", int'(full), 0);
    chk("rst_almost_empty", int'(almost_empty), 1);
    chk("rst_almost_full", int'(almost_full), 0);
    chk("rst_wr_gnt", int'(wr_gnt), 0);
    chk("rst_rd_gnt", int'(rd_gnt), 0);
    chk("rst_w_addr", int'(mem_w_addr), 0);
    chk("rst_r_addr", int'(mem_r_addr), 0);
    chk("rst_rd_valid", int'(rd_valid), 0);
    @(posedge clk);
    #1;
    chk("rst_rd_valid_hold", int'(rd_valid), 0);
    @(negedge clk);
    wr_req = 1'b0;
    rd_req = 1'b0;
    rst_n  = 1'b1;
    $display("reset applied t=%0t", $time);
  endtask

  initial begin
    int pw;
    int pr;
    #2;
    pulse_reset();

    cycle(0, 0);
    cycle(0, 1);                          // pop on empty: no grant
    repeat (4) cycle(1, 0);               // fill to D
    cycle(1, 0);                          // push on full: no grant
    cycle(0, 1);                          // pop from full
    cycle(0, 0);
    cycle(0, 1);                          // count 2
    repeat (8) cycle(1, 1);               // round-robin alternation
    repeat (3) cycle(0, 1);               // drain
    repeat (6) begin                      // wrap
      cycle(1, 0);
      cycle(0, 1);
    end
    cycle(1, 1);                          // empty + both: write wins
    cycle(1, 1);
    repeat (2) cycle(1, 0);
    cycle(0, 1);
    pulse_reset();                        // reset right after a read grant
    cycle(0, 0);
    cycle(1, 1);                          // first tie after reset goes to write

    for (int ph = 0; ph < 3; ph++) begin
      pw = (ph == 0) ? 75 : (ph == 1) ? 30 : 55;
      pr = (ph == 0) ? 35 : (ph == 1) ? 80 : 55;
      repeat (150) begin
        cycle(($urandom_range(0, 99) < pw), ($urandom_range(0, 99) < pr));
        if ($urandom_range(0, 199) == 0) pulse_reset();
      end
    end

    repeat (3) cycle(0, 0);
    chk("sb_drained", sb_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/fifo_sched_ctrl.md
Name: fifo_sched_ctrl

Overview:
- Controller and scheduler for the team's register-file FIFO storage: a synchronous array with `2**W` words, write-priority port enables and a registered read.
- The storage performs only one operation per clock. When `wr_en` and `re_en` are both high, the write wins and the read is silently dropped.
- This block owns the write/read pointers, occupancy and status flags, and arbitrates competing push/pop requests so exactly one storage operation is issued per cycle.
- Write data passes directly from the producer to the storage; this block handles only addresses, enables and handshakes.

Parameters:
- `W`, default 2: storage address width; depth `D = 2**W`.
- `AF_LEVEL`, default 3: `almost_full` asserts when `count >= AF_LEVEL`. Legal range 1..D.
- `AE_LEVEL`, default 1: `almost_empty` asserts when `count <= AE_LEVEL`. Legal range 0..D-1.

Ports:
- `clk`  in  1  system clock, all state on rising edge.
- `rst_n`  in  1  asynchronous active-low reset.
- `wr_req`  in  1  producer push request; held until `wr_gnt`.
- `rd_req`  in  1  consumer pop request; held until `rd_gnt`.
- `wr_gnt`  out  1  push accepted this cycle (combinational).
- `rd_gnt`  out  1  pop accepted this cycle (combinational).
- `mem_wr_en`  out  1  storage write enable; equals `wr_gnt`.
- `mem_re_en`  out  1  storage read enable; equals `rd_gnt`.
- `mem_w_addr`  out  W  storage write address; equals `wr_ptr`.
- `mem_r_addr`  out  W  storage read address; equals `rd_ptr`.
- `rd_valid`  out  1  storage `r_data` holds the popped word (registered).
- `count`  out  W+1  occupancy, range 0..D.
- `full`  out  1  `count == D`.
- `empty`  out  1  `count == 0`.
- `almost_full`  out  1  `count >= AF_LEVEL`.
- `almost_empty`  out  1  `count <= AE_LEVEL`.

Behaviour:
Reset (async on `rst_n` low, applies immediately, also mid-operation):
- `wr_ptr`, `rd_ptr`, `count` = 0.
- `rd_valid` = 0.
- `last_gnt` = READ, so the first tie goes to write.
- Resulting outputs: `empty`=1, `full`=0, `almost_empty`=1, `almost_full` = (`AF_LEVEL` == 0, i.e. 0 for legal values).
- Grants during reset are 0.
- Any in-flight read is discarded: `rd_valid` does not pulse after reset release.

Eligibility:
- `wr_ok = wr_req & !full`.
- `rd_ok = rd_req & !empty`.

Arbitration (exactly one grant max per cycle; `wr_gnt` and `rd_gnt` are never high together):
- Only `wr_ok` → `wr_gnt`.
- Only `rd_ok` → `rd_gnt`.
- Both → grant the op opposite to `last_gnt` (round-robin).
- `last_gnt` updates only on a grant.

State updates on a rising edge:
- On `wr_gnt`: `wr_ptr` +1 mod D (natural W-bit wrap), `count` +1.
- On `rd_gnt`: `rd_ptr` +1 mod D, `count` −1.
- `count` never exceeds D and never underflows, guaranteed by eligibility.

Read latency:
- `rd_valid` is registered `rd_gnt`: high exactly the cycle after the grant, 1-cycle pulse.
- Storage `r_data` stays stable until the next `mem_re_en`.
- Consumer must sample `r_data` while `rd_valid` = 1.

Boundary conditions:
- Empty plus both requests: write granted; read waits. No same-cycle bypass. The read is granted next cycle if the write is not retried, or by round-robin.
- Full plus both requests: read granted.
- Push when full or pop when empty: no grant; the request stalls. No error state.
- Pointer wrap from D−1 to 0 is seamless.
- Flags derive combinationally from registered `count`, so they change the cycle after the grant edge.
- Requests may drop without a grant (withdrawal allowed) with no side effects.

Test Plan (W=2, D=4, AF=3, AE=1):
- Reset then idle: `empty`=1, `full`=0, `count`=0, `almost_empty`=1, no grants, `rd_valid`=0. Asserting `rd_req` alone → no `rd_gnt`.
- Four single-cycle pushes (`wr_req` only): `wr_gnt` each cycle, `mem_w_addr` 0,1,2,3. `count` 1→4; `almost_full` at 3; `full` at 4. Fifth push → `wr_gnt`=0, `mem_wr_en`=0.
- Pop from full: `rd_gnt`, `mem_r_addr`=0. Next cycle `rd_valid`=1 for one cycle, `count`=3, `full`=0.
- `wr_req` and `rd_req` held together, `count`=2: grants alternate W,R,W,R…, starting with W after reset. `count` oscillates 3,2,3,2. Never both grants in one cycle.
- Wrap: 6 pushes interleaved with 6 pops → `mem_w_addr` and `mem_r_addr` go 0,1,2,3,0,1. Popped sequence matches pushed data order.
- `rst_n` low for one cycle immediately after a `rd_gnt`: `rd_valid` stays 0, `count`=0, both pointers 0, `empty`=1 asynchronously.
